// File: rtl/mem_stage_ctrl_if.sv
// MEM-stage bundle: latched MEM fields, data-memory port, MEM->WB register and forwarding.
// master drives the MEM fields and memory/WB responses; slave is the MEM-stage controller.
interface mem_stage_ctrl_if;
  logic        mem_valid;
  logic        dmem_we;
  logic        rf_we;
  logic        bypass_rdc_valid;
  logic [31:0] rt;
  logic [31:0] alu_result;
  logic [4:0]  rdc_mem;
  logic [1:0]  rd_mux_sel;
  logic [31:0] lo;
  logic [31:0] hi;
  logic        mem_allowin;
  logic        dmem_req;
  logic        dmem_wr;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        wb_allowin;
  logic        wb_valid;
  logic        wb_rf_we;
  logic        wb_bypass_rdc_valid;
  logic [4:0]  wb_rdc;
  logic [31:0] wb_data;
  logic        fwd_valid;
  logic        fwd_data_ok;
  logic [31:0] fwd_data;

  modport master (
    output mem_valid, dmem_we, rf_we, bypass_rdc_valid, rt, alu_result, rdc_mem, rd_mux_sel,
    output lo, hi, dmem_ready, dmem_rdata, wb_allowin,
    input  mem_allowin, dmem_req, dmem_wr, dmem_addr, dmem_wdata,
    input  wb_valid, wb_rf_we, wb_bypass_rdc_valid, wb_rdc, wb_data,
    input  fwd_valid, fwd_data_ok, fwd_data
  );

  modport slave (
    input  mem_valid, dmem_we, rf_we, bypass_rdc_valid, rt, alu_result, rdc_mem, rd_mux_sel,
    input  lo, hi, dmem_ready, dmem_rdata, wb_allowin,
    output mem_allowin, dmem_req, dmem_wr, dmem_addr, dmem_wdata,
    output wb_valid, wb_rf_we, wb_bypass_rdc_valid, wb_rdc, wb_data,
    output fwd_valid, fwd_data_ok, fwd_data
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: data-memory access over req/ready, write-back select, MEM->WB register
// and MEM-stage forwarding source.
module mem_stage_ctrl (
  input logic             clk,
  input logic             rst_n,
  mem_stage_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StHold = 2'd2
  } state_e;

  state_e      r_state, w_state_nxt;
  logic [31:0] r_hold, w_hold_nxt;
  logic        r_wb_valid, r_wb_rf_we, r_wb_bypass;
  logic [4:0]  r_wb_rdc;
  logic [31:0] r_wb_data;

  logic        w_is_load, w_is_mem, w_in_hold, w_ready_go, w_wb_load;
  logic [31:0] w_load_data, w_result;

  assign w_is_load   = bus.rf_we & (bus.rd_mux_sel == 2'b01);
  assign w_is_mem    = bus.dmem_we | w_is_load;
  assign w_in_hold   = (r_state == StHold);
  assign w_ready_go  = !w_is_mem | w_in_hold | bus.dmem_ready;
  assign w_load_data = w_in_hold ? r_hold : bus.dmem_rdata;
  assign w_wb_load   = bus.wb_allowin & bus.mem_valid & w_ready_go;

  always_comb begin
    w_result = bus.alu_result;
    case (bus.rd_mux_sel)
      2'b00:   w_result = bus.alu_result;
      2'b01:   w_result = w_load_data;
      2'b10:   w_result = bus.lo;
      default: w_result = bus.hi;
    endcase
  end

  // No request from HOLD: the access already completed, re-issuing would duplicate a store.
  assign bus.dmem_req    = rst_n & bus.mem_valid & w_is_mem & !w_in_hold;
  assign bus.dmem_wr     = bus.dmem_we;
  assign bus.dmem_addr   = bus.alu_result;
  assign bus.dmem_wdata  = bus.rt;
  assign bus.mem_allowin = !bus.mem_valid | (w_ready_go & bus.wb_allowin);
  assign bus.fwd_valid   = bus.mem_valid & bus.rf_we & bus.bypass_rdc_valid;
  assign bus.fwd_data_ok = w_ready_go;
  assign bus.fwd_data    = w_result;

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    unique case (r_state)
      StIdle: begin
        if (bus.mem_valid & w_is_mem) begin
          if (!bus.dmem_ready) begin
            w_state_nxt = StReq;
          end else if (!bus.wb_allowin) begin
            w_state_nxt = StHold;
            w_hold_nxt  = bus.dmem_rdata;
          end
        end
      end
      StReq: begin
        if (bus.dmem_ready) begin
          if (bus.wb_allowin) begin
            w_state_nxt = StIdle;
          end else begin
            w_state_nxt = StHold;
            w_hold_nxt  = bus.dmem_rdata;
          end
        end
      end
      StHold: begin
        if (bus.wb_allowin) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_hold  <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid  <= 1'b0;
      r_wb_rf_we  <= 1'b0;
      r_wb_bypass <= 1'b0;
      r_wb_rdc    <= 5'd0;
      r_wb_data   <= 32'h0;
    end else begin
      if (bus.wb_allowin) r_wb_valid <= bus.mem_valid & w_ready_go;
      if (w_wb_load) begin
        r_wb_rf_we  <= bus.rf_we;
        r_wb_bypass <= bus.bypass_rdc_valid;
        r_wb_rdc    <= bus.rdc_mem;
        r_wb_data   <= w_result;
      end
    end
  end

  assign bus.wb_valid            = r_wb_valid;
  assign bus.wb_rf_we            = r_wb_rf_we;
  assign bus.wb_bypass_rdc_valid = r_wb_bypass;
  assign bus.wb_rdc              = r_wb_rdc;
  assign bus.wb_data             = r_wb_data;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios with literal expectations plus a per-cycle
// comparison against an "access done / held data" behavioural model.
module tb_mem_stage_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail = 0;

  mem_stage_ctrl_if bus ();

  mem_stage_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an op's memory access is either still pending or done; done data is kept until WB.
  bit          m_done = 0;
  logic [31:0] m_held = 32'h0;
  logic        m_wb_valid = 0, m_wb_rf_we = 0, m_wb_byp = 0;
  logic [4:0]  m_wb_rdc = 0;
  logic [31:0] m_wb_data = 0;

  function automatic bit e_is_mem();
    return bus.dmem_we | (bus.rf_we & (bus.rd_mux_sel == 2'b01));
  endfunction

  function automatic bit e_ready_go();
    return !e_is_mem() | m_done | bus.dmem_ready;
  endfunction

  function automatic logic [31:0] e_result();
    logic [31:0] sel_vals [4];
    sel_vals[0] = bus.alu_result;
    sel_vals[1] = m_done ? m_held : bus.dmem_rdata;
    sel_vals[2] = bus.lo;
    sel_vals[3] = bus.hi;
    return sel_vals[bus.rd_mux_sel];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_done = 0; m_held = 0;
      m_wb_valid = 0; m_wb_rf_we = 0; m_wb_byp = 0; m_wb_rdc = 0; m_wb_data = 0;
    end else begin
      bit rg;
      logic [31:0] res;
      rg  = e_ready_go();
      res = e_result();
      if (bus.wb_allowin) begin
        m_wb_valid = bus.mem_valid & rg;
        if (bus.mem_valid & rg) begin
          m_wb_rf_we = bus.rf_we; m_wb_byp = bus.bypass_rdc_valid;
          m_wb_rdc = bus.rdc_mem; m_wb_data = res;
        end
      end
      if (bus.mem_valid & e_is_mem()) begin
        if (bus.wb_allowin & rg) m_done = 0;
        else if (!m_done & bus.dmem_ready) begin
          m_done = 1; m_held = bus.dmem_rdata;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_dmem_req", bus.dmem_req, rst_n & bus.mem_valid & e_is_mem() & !m_done);
    chk("m_mem_allowin", bus.mem_allowin, !bus.mem_valid | (e_ready_go() & bus.wb_allowin));
    chk("m_fwd_data_ok", bus.fwd_data_ok, e_ready_go());
    chk("m_fwd_valid", bus.fwd_valid, bus.mem_valid & bus.rf_we & bus.bypass_rdc_valid);
    if (bus.mem_valid) chk("m_fwd_data", bus.fwd_data, e_result());
    chk("m_dmem_wr", bus.dmem_wr, bus.dmem_we);
    chk("m_dmem_addr", bus.dmem_addr, bus.alu_result);
    chk("m_dmem_wdata", bus.dmem_wdata, bus.rt);
    chk("m_wb_valid", bus.wb_valid, m_wb_valid);
    chk("m_wb_rf_we", bus.wb_rf_we, m_wb_rf_we);
    chk("m_wb_byp", bus.wb_bypass_rdc_valid, m_wb_byp);
    chk("m_wb_rdc", bus.wb_rdc, m_wb_rdc);
    chk("m_wb_data", bus.wb_data, m_wb_data);
  end

  int req_cycles = 0, beats = 0, wr_beats = 0;
  always @(posedge clk) begin
    if (bus.dmem_req) req_cycles++;
    if (bus.dmem_req & bus.dmem_ready) beats++;
    if (bus.dmem_req & bus.dmem_ready & bus.dmem_wr) wr_beats++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic we, input logic rfwe, input logic byp, input logic [31:0] rt,
                        input logic [31:0] alu, input logic [4:0] rdc, input logic [1:0] sel);
    bus.dmem_we = we; bus.rf_we = rfwe; bus.bypass_rdc_valid = byp; bus.rt = rt;
    bus.alu_result = alu; bus.rdc_mem = rdc; bus.rd_mux_sel = sel;
  endtask

  initial begin
    int r0, b0, w0;
    rst_n = 1'b0;
    bus.mem_valid = 0; bus.lo = 32'h1; bus.hi = 32'h2;
    bus.dmem_ready = 0; bus.dmem_rdata = 0; bus.wb_allowin = 0;
    set_op(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_wb_rdc", bus.wb_rdc, 0);
    bus.mem_valid = 1; set_op(0, 1, 0, 0, 32'h40, 1, 2'b01);
    #1 chk("rst_req_forced_low", bus.dmem_req, 0);
    bus.mem_valid = 0;
    rst_n = 1'b1;
    tick();

    // ALU op
    set_op(0, 1, 1, 0, 32'h1234, 5, 2'b00);
    bus.mem_valid = 1; bus.wb_allowin = 1;
    #1 chk("alu_allowin", bus.mem_allowin, 1);
    chk("alu_fwd_valid", bus.fwd_valid, 1);
    tick();
    bus.mem_valid = 0;
    chk("alu_wb_valid", bus.wb_valid, 1);
    chk("alu_wb_data", bus.wb_data, 32'h1234);
    chk("alu_wb_rdc", bus.wb_rdc, 5);

    // Load, ready in the third request cycle
    r0 = req_cycles; b0 = beats;
    set_op(0, 1, 1, 0, 32'h40, 7, 2'b01);
    bus.mem_valid = 1; bus.dmem_rdata = 32'h0;
    #1 chk("ld_req_c1", bus.dmem_req, 1);
    chk("ld_allowin_c1", bus.mem_allowin, 0);
    chk("ld_addr", bus.dmem_addr, 32'h40);
    tick();
    chk("ld_allowin_c2", bus.mem_allowin, 0);
    tick();
    bus.dmem_ready = 1; bus.dmem_rdata = 32'hDEADBEEF;
    #1 chk("ld_allowin_c3", bus.mem_allowin, 1);
    chk("ld_fwd_data", bus.fwd_data, 32'hDEADBEEF);
    tick();
    bus.dmem_ready = 0; bus.mem_valid = 0;
    chk("ld_wb_data", bus.wb_data, 32'hDEADBEEF);
    chk("ld_wb_valid", bus.wb_valid, 1);
    chk("ld_req_cycles", req_cycles - r0, 3);
    chk("ld_beats", beats - b0, 1);

    // Store, zero-wait, WB stalled two cycles
    w0 = wr_beats;
    set_op(1, 0, 0, 32'hA5A5A5A5, 32'h80, 3, 2'b00);
    bus.mem_valid = 1; bus.wb_allowin = 0; bus.dmem_ready = 1;
    #1 chk("st_req", bus.dmem_req, 1);
    chk("st_wr", bus.dmem_wr, 1);
    chk("st_wdata", bus.dmem_wdata, 32'hA5A5A5A5);
    tick();
    bus.dmem_ready = 0;
    #1 chk("st_hold_req", bus.dmem_req, 0);
    chk("st_hold_ok", bus.fwd_data_ok, 1);
    chk("st_hold_allowin", bus.mem_allowin, 0);
    tick();
    chk("st_hold_req2", bus.dmem_req, 0);
    bus.wb_allowin = 1;
    #1 chk("st_release_allowin", bus.mem_allowin, 1);
    tick();
    bus.mem_valid = 0;
    chk("st_wb_valid", bus.wb_valid, 1);
    chk("st_wb_rf_we", bus.wb_rf_we, 0);
    chk("st_write_beats", wr_beats - w0, 1);

    // Load completes while WB stalled; read data then goes stale
    set_op(0, 1, 1, 0, 32'h44, 9, 2'b01);
    bus.mem_valid = 1; bus.wb_allowin = 0; bus.dmem_ready = 1; bus.dmem_rdata = 32'h600DF00D;
    tick();
    bus.dmem_ready = 0; bus.dmem_rdata = 32'hBAD0BAD0;
    #1 chk("hold_fwd_data", bus.fwd_data, 32'h600DF00D);
    tick();
    bus.wb_allowin = 1;
    tick();
    bus.mem_valid = 0;
    chk("hold_wb_data", bus.wb_data, 32'h600DF00D);
    chk("hold_wb_rdc", bus.wb_rdc, 9);

    // LO / HI select
    set_op(0, 1, 0, 0, 32'hFFFF, 4, 2'b10);
    bus.mem_valid = 1;
    tick();
    chk("lo_wb_data", bus.wb_data, 32'h1);
    set_op(0, 1, 0, 0, 32'hFFFF, 4, 2'b11);
    tick();
    chk("hi_wb_data", bus.wb_data, 32'h2);

    // Reset while a load is outstanding
    set_op(0, 1, 1, 0, 32'h48, 6, 2'b01);
    bus.dmem_ready = 0;
    tick();
    chk("rq_req_before_rst", bus.dmem_req, 1);
    rst_n = 1'b0;
    #1 chk("rq_req_in_rst", bus.dmem_req, 0);
    chk("rq_wb_valid_in_rst", bus.wb_valid, 0);
    bus.mem_valid = 0;
    tick();
    tick();
    rst_n = 1'b1;
    bus.mem_valid = 1; bus.dmem_ready = 1; bus.dmem_rdata = 32'h11112222;
    #1 chk("rq_req_after_rst", bus.dmem_req, 1);
    chk("rq_fwd_live", bus.fwd_data, 32'h11112222);
    tick();
    bus.mem_valid = 0; bus.dmem_ready = 0;
    chk("rq_wb_data", bus.wb_data, 32'h11112222);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
